// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the fetch-engine request/response channel.
// Read requests are accepted on the m_req_* handshake. Each request looks up a
// local word array with a fixed READ_LAT-cycle pipeline. It then joins a small
// response FIFO that drives the m_rsp_* handshake. Responses always come back
// in request order.
//
// Flow control is credit based. Every accepted request holds a credit until
// its response is popped. Because of this, the FIFO can never overflow and no
// response is ever dropped.
//
// Configuration macro: MEM_PRELOAD_EN
//   defined   : adds write ports wr_en / wr_addr / wr_data. A write and a read
//               of the same address in one cycle returns the OLD data.
//   undefined : no write ports. The array is preloaded by the environment.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   m_req_vld    in   request valid
//   m_req_rdy    out  request ready (a credit is available)
//   m_req_addr   in   word address (ADDR_WIDTH)
//   m_rsp_vld    out  response valid (FIFO not empty)
//   m_rsp_rdy    in   consumer ready
//   m_rsp_data   out  read data at the FIFO head; 0 while m_rsp_vld is low
//   addr_err     out  sticky flag: an out-of-range address was accepted
//   outstanding  out  requests accepted but not yet popped
//   wr_en        in   (MEM_PRELOAD_EN only) write strobe
//   wr_addr      in   (MEM_PRELOAD_EN only) write address
//   wr_data      in   (MEM_PRELOAD_EN only) write data
//
// Parameter constraints
//   RSP_FIFO_DEPTH must be a power of 2, >= 2 and >= READ_LAT.
//   READ_LAT must be >= 1.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH      = 256,
    parameter int READ_LAT       = 2,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              m_req_vld,
    output logic                              m_req_rdy,
    input  logic [ADDR_WIDTH-1:0]             m_req_addr,
    output logic                              m_rsp_vld,
    input  logic                              m_rsp_rdy,
    output logic [DATA_WIDTH-1:0]             m_rsp_data,
    output logic                              addr_err,
    output logic [$clog2(RSP_FIFO_DEPTH):0]   outstanding
`ifdef MEM_PRELOAD_EN
    ,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data
`endif
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // One extra bit lets the range check see addresses >= MEM_DEPTH
    // even when MEM_DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    // ---------------------------------------------------------------
    // Storage and pipeline registers
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0]                 r_mem [MEM_DEPTH];
    logic [READ_LAT-1:0][DATA_WIDTH-1:0]   r_pipe_data;
    logic [READ_LAT-1:0]                   r_pipe_vld;
    logic [READ_LAT-1:0]                   r_pipe_err;

    logic [DATA_WIDTH-1:0]                 r_fifo [RSP_FIFO_DEPTH];
    logic [PTR_W:0]                        r_wr_ptr;
    logic [PTR_W:0]                        r_rd_ptr;

    logic [CNT_W-1:0]                      r_outstanding;
    logic                                  r_addr_err;

    logic                                  w_accept;
    logic                                  w_pop;
    logic                                  w_fifo_empty;
    logic                                  w_req_in_range;
    logic                                  w_push;
    logic [DATA_WIDTH-1:0]                 w_push_data;
    logic [IDX_W-1:0]                      w_rd_idx;

    // ---------------------------------------------------------------
    // Handshake decode
    // ---------------------------------------------------------------
    // Because every accept reserves a FIFO slot, ready needs only the counter.
    assign m_req_rdy      = (r_outstanding < CNT_W'(RSP_FIFO_DEPTH));
    assign w_accept       = m_req_vld & m_req_rdy;
    assign w_fifo_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_pop          = ~w_fifo_empty & m_rsp_rdy;
    assign w_req_in_range = ({1'b0, m_req_addr} < DEPTH_LIM);
    assign w_rd_idx       = m_req_addr[IDX_W-1:0];

    // ---------------------------------------------------------------
    // Memory array and data pipeline (no reset so it maps to block RAM).
    // Stage 0 is the registered RAM read. The write lands in the same
    // block, so a same-address read in that cycle returns the old word.
    // The array is read every cycle. The valid/err shift below decides
    // whether the data is used.
    // ---------------------------------------------------------------
`ifdef MEM_PRELOAD_EN
    logic w_wr_ok;
    assign w_wr_ok = wr_en & ({1'b0, wr_addr} < DEPTH_LIM);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
        r_pipe_data[0] <= r_mem[w_rd_idx];
        for (int i = 1; i < READ_LAT; i++) begin
            r_pipe_data[i] <= r_pipe_data[i-1];
        end
    end
`else
    always_ff @(posedge clk) begin
        r_pipe_data[0] <= r_mem[w_rd_idx];
        for (int i = 1; i < READ_LAT; i++) begin
            r_pipe_data[i] <= r_pipe_data[i-1];
        end
    end
`endif

    // The valid/err shift runs alongside the data pipeline. The err bit
    // marks out-of-range requests; their data is replaced by 0 at the
    // FIFO input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            r_pipe_err <= '0;
        end else begin
            r_pipe_vld[0] <= w_accept;
            r_pipe_err[0] <= w_accept & ~w_req_in_range;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_err[i] <= r_pipe_err[i-1];
            end
        end
    end

    assign w_push      = r_pipe_vld[READ_LAT-1];
    assign w_push_data = r_pipe_err[READ_LAT-1] ? '0 : r_pipe_data[READ_LAT-1];

    // ---------------------------------------------------------------
    // Response FIFO.
    // The pointers carry one extra wrap bit: the FIFO is empty when the
    // pointers are equal and full when only the wrap bit differs. The
    // credit counter already guarantees a free slot for every push, so
    // the push path does not check for full.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W + 1)'(1);
            end
        end
    end

    // The head entry cannot change while it is valid and not popped, so
    // the data holds stable under backpressure. It reads 0 when the FIFO
    // is empty.
    assign m_rsp_vld  = ~w_fifo_empty;
    assign m_rsp_data = w_fifo_empty ? '0 : r_fifo[r_rd_ptr[PTR_W-1:0]];

    // ---------------------------------------------------------------
    // Credit counter and sticky error flag
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_addr_err    <= 1'b0;
        end else begin
            if (w_accept && !w_pop) begin
                r_outstanding <= r_outstanding + CNT_W'(1);
            end else if (!w_accept && w_pop) begin
                r_outstanding <= r_outstanding - CNT_W'(1);
            end
            if (w_accept && !w_req_in_range) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign outstanding = r_outstanding;
    assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Reference model: a word array mirroring the memory, plus a queue of
// expected responses. Each queue entry holds its data and the cycle at which
// it becomes visible (accept edge + READ_LAT). A credit count and a sticky
// error flag complete the model. Fixed scenarios come first, followed by
// randomized traffic.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int RL    = 2;
    localparam int FD    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          m_req_vld = 1'b0;
    logic          m_req_rdy;
    logic [AW-1:0] m_req_addr = '0;
    logic          m_rsp_vld;
    logic          m_rsp_rdy = 1'b0;
    logic [DW-1:0] m_rsp_data;
    logic          addr_err;
    logic [2:0]    outstanding;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MEM_DEPTH      (DEPTH),
        .READ_LAT       (RL),
        .RSP_FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_req_vld   (m_req_vld),
        .m_req_rdy   (m_req_rdy),
        .m_req_addr  (m_req_addr),
        .m_rsp_vld   (m_rsp_vld),
        .m_rsp_rdy   (m_rsp_rdy),
        .m_rsp_data  (m_rsp_data),
        .addr_err    (addr_err),
        .outstanding (outstanding)
`ifdef MEM_PRELOAD_EN
        ,
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
`endif
    );

    // Reference model state
    logic [DW-1:0] mem_model [DEPTH];
    logic [DW-1:0] exp_q [$];
    longint        due_q [$];
    int            m_out   = 0;
    bit            m_err   = 1'b0;
    longint        cyc     = 0;
    int            n_vec   = 0;
    int            n_bad   = 0;
    int            n_rsp   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock of traffic. Call at a negedge; returns at the next negedge.
    // Outputs are checked before the edge, then the model is advanced.
    task automatic cycle(input bit vld, input logic [AW-1:0] addr, input bit rdy, output bit acc);
        bit exp_rdy;
        bit exp_vld;
        m_req_vld  = vld;
        m_req_addr = addr;
        m_rsp_rdy  = rdy;
        exp_rdy = (m_out < FD);
        exp_vld = (exp_q.size() > 0) && (due_q[0] <= cyc);
        check_val("req_rdy", m_req_rdy, exp_rdy);
        check_val("outstanding", outstanding, m_out);
        check_val("rsp_vld", m_rsp_vld, exp_vld);
        check_val("addr_err", addr_err, m_err);
        if (exp_vld) check_val("rsp_data", m_rsp_data, exp_q[0]);
        acc = vld && exp_rdy;
        @(posedge clk);
        cyc++;
        if (exp_vld && rdy) begin
            $display("rsp %0d data=%08h", n_rsp, exp_q[0]);
            n_rsp++;
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            m_out--;
        end
        if (acc) begin
            // The read sees the memory before any same-cycle write.
            exp_q.push_back((int'(addr) < DEPTH) ? mem_model[int'(addr)] : '0);
            due_q.push_back(cyc + RL);
            m_out++;
            if (int'(addr) >= DEPTH) m_err = 1'b1;
        end
        if (wr_en && int'(wr_addr) < DEPTH) mem_model[int'(wr_addr)] = wr_data;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        m_req_vld  = 1'b1;
        m_req_addr = 16'd5;
        m_rsp_rdy  = 1'b0;
        #1;
        exp_q.delete();
        due_q.delete();
        m_out = 0;
        m_err = 1'b0;
        check_val("rst_req_rdy", m_req_rdy, 1);
        check_val("rst_rsp_vld", m_rsp_vld, 0);
        check_val("rst_outstanding", outstanding, 0);
        check_val("rst_addr_err", addr_err, 0);
        check_val("rst_rsp_data", m_rsp_data, 0);
        @(negedge clk);
        check_val("rst_hold_rsp_vld", m_rsp_vld, 0);
        check_val("rst_hold_outstanding", outstanding, 0);
        rst_n     = 1'b1;
        m_req_vld = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int guard = 0;
        while (exp_q.size() > 0 && guard < 60) begin
            cycle(1'b0, '0, 1'b1, acc);
            guard++;
        end
        if (exp_q.size() > 0) check_val("drain_timeout", exp_q.size(), 0);
        cycle(1'b0, '0, 1'b1, acc);
    endtask

    initial begin
        bit acc;
        int cnt;
        @(negedge clk);

        // Reset with a request held valid
        do_reset();

        // Memory image (mem[5] = DEADBEEF)
`ifdef MEM_PRELOAD_EN
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = (i == 5) ? 32'hDEADBEEF : $urandom;
            cycle(1'b0, '0, 1'b1, acc);
        end
        wr_en = 1'b0;
`else
        for (int i = 0; i < DEPTH; i++) begin
            mem_model[i] = (i == 5) ? 32'hDEADBEEF : $urandom;
            dut.r_mem[i] = mem_model[i];
        end
`endif

        // Single read: response valid exactly READ_LAT edges later, for one cycle
        cycle(1'b1, 16'd5, 1'b1, acc);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, acc);

        // Back-to-back streaming
        for (int i = 0; i < 16; i++) cycle(1'b1, AW'(i), 1'b1, acc);
        drain();

        // Backpressure: only FD requests fit while the consumer stalls
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, AW'(20 + cnt), 1'b0, acc);
            if (acc) cnt++;
        end
        check_val("bp_req_rdy_low", m_req_rdy, 0);
        check_val("bp_outstanding_full", outstanding, FD);
        for (int i = 0; i < 20 && cnt < 6; i++) begin
            cycle(1'b1, AW'(20 + cnt), 1'b1, acc);
            if (acc) cnt++;
        end
        drain();

        // Out-of-range request between two valid ones, then idle
        cycle(1'b1, 16'd1, 1'b1, acc);
        cycle(1'b1, 16'd300, 1'b1, acc);
        cycle(1'b1, 16'd2, 1'b1, acc);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, acc);
        check_val("oor_err_sticky", addr_err, 1);

        // Reset while requests are in flight; nothing may come out afterwards
        for (int i = 0; i < 3; i++) cycle(1'b1, AW'(40 + i), 1'b0, acc);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, acc);

`ifdef MEM_PRELOAD_EN
        // Same-cycle write/read of one address returns the old word
        wr_en = 1'b1; wr_addr = 16'd7; wr_data = 32'h12345678;
        cycle(1'b1, 16'd7, 1'b1, acc);
        wr_en = 1'b0;
        cycle(1'b1, 16'd7, 1'b1, acc);
        drain();
`endif

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 65535))
                                            : AW'($urandom_range(0, DEPTH - 1));
`ifdef MEM_PRELOAD_EN
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom_range(0, 300));
            wr_data = $urandom;
`endif
            cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0, acc);
        end
        wr_en = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
